// File: rtl/bridge_pkg.sv
// Shared types and helpers for the CPU-bus to pin-lane bridge.
// Holds the FSM state enum, the pin_phase encodings and the beat-count helper.
package bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StTurn,
        StRecv,
        StDone
    } state_e;

    localparam logic [1:0] PhaseIdle = 2'd0;
    localparam logic [1:0] PhaseSend = 2'd1;
    localparam logic [1:0] PhaseTurn = 2'd2;
    localparam logic [1:0] PhaseRecv = 2'd3;

    function automatic int unsigned beats(input int unsigned width, input int unsigned lane);
        return width / lane;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lane_shifter.sv
// Lane-granular shift register: parallel load, shift toward beat 0 with a new lane
// entering at the top, so it serves both serialisation and deserialisation.
module lane_shifter #(
    parameter int unsigned Width = 32,
    parameter int unsigned LaneW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_data_i,
    input  logic             shift_i,
    input  logic [LaneW-1:0] serial_i,
    output logic [LaneW-1:0] serial_o,
    output logic [Width-1:0] data_next_o
);

    logic [Width-1:0]       data_q, data_d;
    logic [Width+LaneW-1:0] shifted;

    assign shifted = {serial_i, data_q};

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = shifted[Width+LaneW-1:LaneW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign serial_o    = data_q[LaneW-1:0];
    assign data_next_o = data_d;

endmodule

// File: rtl/bus_lane_bridge.sv
// Single-transaction bridge from the CPU parallel bus to narrow pin lanes, with
// external wait states, a one-cycle bus turnaround for reads and a CPU ack pulse.
module bus_lane_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_busy,
    output logic [LANE_W-1:0] pin_addr,
    output logic [LANE_W-1:0] pin_wdata,
    output logic [LANE_W-1:0] pin_oe,
    input  logic [LANE_W-1:0] pin_rdata,
    input  logic              pin_ready,
    output logic [1:0]        pin_phase,
    output logic              pin_frame,
    output logic              pin_we
);

    localparam int unsigned AB   = beats(ADDR_W, LANE_W);
    localparam int unsigned DB   = beats(DATA_W, LANE_W);
    localparam int unsigned SB   = max_u(AB, DB);
    localparam int unsigned CntW = $clog2(SB + 1);

    localparam logic [CntW-1:0] SendLast = CntW'(SB - 1);
    localparam logic [CntW-1:0] RecvLast = CntW'(DB - 1);

    if (LANE_W == 0) begin : g_lane_chk
        $error("LANE_W must be non-zero");
    end
    if (ADDR_W % LANE_W != 0) begin : g_addr_chk
        $error("ADDR_W must be a multiple of LANE_W");
    end
    if (DATA_W % LANE_W != 0) begin : g_data_chk
        $error("DATA_W must be a multiple of LANE_W");
    end

    state_e            state_q, state_d;
    logic [CntW-1:0]   beat_q, beat_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              accept;
    logic              send_step;
    logic              recv_step;
    logic              in_send;
    logic [LANE_W-1:0] addr_lane;
    logic [LANE_W-1:0] wdata_lane;
    logic [LANE_W-1:0] rx_lane_unused;
    logic [ADDR_W-1:0] addr_next_unused;
    logic [DATA_W-1:0] wdata_next_unused;
    logic [DATA_W-1:0] rx_next;
    logic              unused_shift;

    assign accept    = (state_q == StIdle) && cpu_req;
    assign send_step = (state_q == StSend) && pin_ready;
    assign recv_step = (state_q == StRecv) && pin_ready;
    assign in_send   = (state_q == StSend);

    // Zeros shift in behind the payload, so beats past AB/DB come out as 0.
    lane_shifter #(
        .Width (ADDR_W),
        .LaneW (LANE_W)
    ) u_addr_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .load_data_i (cpu_addr),
        .shift_i     (send_step),
        .serial_i    ('0),
        .serial_o    (addr_lane),
        .data_next_o (addr_next_unused)
    );

    lane_shifter #(
        .Width (DATA_W),
        .LaneW (LANE_W)
    ) u_wdata_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .load_data_i (cpu_we ? cpu_wdata : '0),
        .shift_i     (send_step),
        .serial_i    ('0),
        .serial_o    (wdata_lane),
        .data_next_o (wdata_next_unused)
    );

    lane_shifter #(
        .Width (DATA_W),
        .LaneW (LANE_W)
    ) u_rdata_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .load_data_i ('0),
        .shift_i     (recv_step),
        .serial_i    (pin_rdata),
        .serial_o    (rx_lane_unused),
        .data_next_o (rx_next)
    );

    assign unused_shift = ^{rx_lane_unused, addr_next_unused, wdata_next_unused};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    state_d = StSend;
                    beat_d  = '0;
                    we_d    = cpu_we;
                end
            end
            StSend: begin
                if (pin_ready) begin
                    if (beat_q == SendLast) begin
                        beat_d  = '0;
                        state_d = we_q ? StDone : StTurn;
                    end else begin
                        beat_d = beat_q + CntW'(1);
                    end
                end
            end
            StTurn: begin
                state_d = StRecv;
            end
            StRecv: begin
                if (pin_ready) begin
                    if (beat_q == RecvLast) begin
                        beat_d  = '0;
                        state_d = StDone;
                        // Commit the fully assembled word so it is visible in the ack cycle.
                        rdata_d = rx_next;
                    end else begin
                        beat_d = beat_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                beat_d  = '0;
            end
        endcase
    end

    always_comb begin
        pin_phase = PhaseIdle;
        unique case (state_q)
            StSend:  pin_phase = PhaseSend;
            StTurn:  pin_phase = PhaseTurn;
            StRecv:  pin_phase = PhaseRecv;
            default: pin_phase = PhaseIdle;
        endcase
        cpu_ack   = (state_q == StDone);
        cpu_busy  = (state_q != StIdle);
        pin_oe    = {LANE_W{in_send}};
        pin_frame = in_send && (beat_q == '0);
        pin_addr  = in_send ? addr_lane : '0;
        pin_wdata = in_send ? wdata_lane : '0;
        pin_we    = we_q;
        cpu_rdata = rdata_q;
    end

endmodule

// File: tb/tb_bus_lane_bridge.sv
// Scoreboard bench for bus_lane_bridge: a driver queues expected transactions, a
// negedge monitor checks every pin beat and each ack against them.
module tb_bus_lane_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_busy;
    logic [7:0]  pin_addr, pin_wdata, pin_oe, pin_rdata;
    logic        pin_ready, pin_frame, pin_we;
    logic [1:0]  pin_phase;

    logic        req16;
    logic [15:0] addr16;
    logic [31:0] rdata16;
    logic        ack16, busy16, frame16, we16;
    logic [7:0]  paddr16, pwdata16, poe16;
    logic [1:0]  phase16;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          sbeat = 0;
    int          rbeat = 0;
    logic [31:0] last_rdata = '0;

    always #5 clk = ~clk;

    bus_lane_bridge #(.ADDR_W(32), .DATA_W(32), .LANE_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_busy  (cpu_busy),
        .pin_addr  (pin_addr),
        .pin_wdata (pin_wdata),
        .pin_oe    (pin_oe),
        .pin_rdata (pin_rdata),
        .pin_ready (pin_ready),
        .pin_phase (pin_phase),
        .pin_frame (pin_frame),
        .pin_we    (pin_we)
    );

    bus_lane_bridge #(.ADDR_W(16), .DATA_W(32), .LANE_W(8)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (req16),
        .cpu_we    (1'b1),
        .cpu_addr  (addr16),
        .cpu_wdata (32'hCAFE_BABE),
        .cpu_rdata (rdata16),
        .cpu_ack   (ack16),
        .cpu_busy  (busy16),
        .pin_addr  (paddr16),
        .pin_wdata (pwdata16),
        .pin_oe    (poe16),
        .pin_rdata (pin_rdata),
        .pin_ready (pin_ready),
        .pin_phase (phase16),
        .pin_frame (frame16),
        .pin_we    (we16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: reference beats come from plain shifts of the queued transaction.
    initial begin
        txn_t        t;
        logic [7:0]  ea, ew;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs", {cpu_ack, cpu_busy, pin_addr, pin_wdata, pin_oe, pin_phase,
                                      pin_frame, pin_we, cpu_rdata}, '0);
                exp_q.delete();
                sbeat = 0;
                rbeat = 0;
                last_rdata = '0;
            end else begin
                if (cpu_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", {63'd0, cpu_ack}, 64'd0);
                    end else begin
                        t = exp_q.pop_front();
                        chk("send_beats", sbeat, 4);
                        chk("recv_beats", rbeat, t.we ? 0 : 4);
                        if (!t.we) last_rdata = t.rdata;
                        chk("ack_rdata", cpu_rdata, last_rdata);
                    end
                    sbeat = 0;
                    rbeat = 0;
                end else begin
                    chk("rdata_hold", cpu_rdata, last_rdata);
                end
                case (pin_phase)
                    2'd1: begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_send", pin_phase, 0);
                        end else begin
                            t  = exp_q[0];
                            ea = (sbeat < 4) ? 8'(t.addr >> (8 * sbeat)) : 8'h00;
                            ew = (t.we && sbeat < 4) ? 8'(t.wdata >> (8 * sbeat)) : 8'h00;
                            chk("send_beat", {pin_addr, pin_wdata, pin_oe, pin_frame, pin_we},
                                {ea, ew, 8'hFF, (sbeat == 0), t.we});
                            if (pin_ready) sbeat++;
                        end
                    end
                    2'd2: chk("oe_turn", pin_oe, 0);
                    2'd3: begin
                        chk("oe_recv", pin_oe, 0);
                        if (pin_ready) rbeat++;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Drives one transaction and acts as the pin-side device; lat = ack cycle after E0.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic [31:0] stall_mask,
                           input bit rnd, input bit hold, input bit from_done,
                           input int abort_cyc, output int lat);
        txn_t t;
        int   n;
        int   rb;
        int   guard;
        if (!from_done) begin
            guard = 0;
            while (cpu_busy && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
        end
        t.we = we;
        t.addr = addr;
        t.wdata = wdata;
        t.rdata = rdata;
        exp_q.push_back(t);
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wdata;
        cpu_req = 1'b1;
        if (from_done) begin
            @(posedge clk);
            #1;
            chk("b2b_idle", {cpu_busy, pin_frame}, 2'b00);
        end
        @(posedge clk);
        #1;
        if (from_done) chk("b2b_frame", pin_frame, 1);
        if (!hold) cpu_req = 1'b0;
        n = 1;
        rb = 0;
        lat = -1;
        while (n < 200) begin
            pin_ready = rnd ? ($urandom_range(0, 3) != 0) : !(n < 32 && stall_mask[n]);
            if (pin_phase == 2'd3) begin
                pin_rdata = pin_ready ? 8'(rdata >> (8 * rb)) : 8'($urandom);
                if (pin_ready) rb++;
            end else begin
                pin_rdata = 8'($urandom);
            end
            if (cpu_ack) begin
                lat = n;
                break;
            end
            if (n == abort_cyc) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_outputs", {cpu_ack, cpu_busy, pin_addr, pin_wdata, pin_oe, pin_phase,
                                      pin_frame, cpu_rdata}, '0);
                @(posedge clk);
                #1;
                chk("abort_no_ack", {cpu_ack, cpu_rdata}, '0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                lat = 0;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (lat < 0) chk("ack_timeout", {63'd0, cpu_ack}, 64'd1);
    endtask

    initial begin
        int lat;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        pin_ready = 1'b0;
        pin_rdata = '0;
        req16 = 1'b0;
        addr16 = 16'h5678;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_txn(1'b1, 32'h1234_5678, 32'hCAFE_BABE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, lat);
        chk("write_ack_cycle", lat, 5);
        run_txn(1'b0, 32'h0000_00A5, 32'h0, 32'h4433_2211, 32'h0, 1'b0, 1'b0, 1'b0, 0, lat);
        chk("read_ack_cycle", lat, 10);
        chk("read_rdata", cpu_rdata, 32'h4433_2211);
        run_txn(1'b0, 32'h8765_4321, 32'h0, 32'hDEAD_BEEF, 32'h0000_0C38, 1'b0, 1'b0, 1'b0, 0,
                lat);
        chk("stall_ack_cycle", lat, 15);

        // Narrow-address instance: beats 2-3 carry a zero address lane.
        @(posedge clk);
        #1 req16 = 1'b1;
        pin_ready = 1'b1;
        @(posedge clk);
        #1 req16 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("a16_beat", {paddr16, pwdata16, poe16},
                {(k < 2) ? 8'(16'h5678 >> (8 * k)) : 8'h00, 8'(32'hCAFE_BABE >> (8 * k)), 8'hFF});
            @(posedge clk);
            #1;
        end
        chk("a16_ack", {ack16, busy16}, 2'b11);

        run_txn(1'b0, 32'h0BAD_F00D, 32'h0, 32'h5555_AAAA, 32'h0, 1'b0, 1'b0, 1'b0, 8, lat);
        chk("post_abort_rdata", cpu_rdata, 0);
        run_txn(1'b0, 32'h0000_1000, 32'h0, 32'h0F1E_2D3C, 32'h0, 1'b0, 1'b0, 1'b0, 0, lat);
        chk("post_abort_read", lat, 10);

        run_txn(1'b1, 32'hA0A0_0001, 32'h1111_1111, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0, lat);
        chk("b2b_ack0", lat, 5);
        run_txn(1'b1, 32'hA0A0_0002, 32'h2222_2222, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 0, lat);
        chk("b2b_ack1", lat, 5);
        run_txn(1'b1, 32'hA0A0_0003, 32'h3333_3333, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 0, lat);
        chk("b2b_ack2", lat, 5);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 32'h0, 1'b1, 1'b0,
                    1'b0, 0, lat);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_lane_bridge.md
# bus_lane_bridge

Parametrised bridge between the CPU core's parallel bus and the narrow chip pin lanes. Accepts one read or write transaction at a time from the CPU side, serialises address and write data onto LANE_W-wide output lanes over multiple beats, and for reads deserialises the returned data from the input lane. It sits in the top-level pin wrapper between the CPU instance and the dedicated and bidirectional I/O pins. Unlike the fixed 32-bit/8-bit sequencer it replaces, it supports external wait states and unequal address and data widths, and it provides an explicit CPU handshake.

## Interface
Parameters:
- ADDR_W, 32, CPU address width; must be a multiple of LANE_W.
- DATA_W, 32, CPU data width; must be a multiple of LANE_W.
- LANE_W, 8, pin lane width.

Ports:
- clk  in  1  single clock; all state changes occur on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cpu_req  in  1  transaction request; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read; latched with cpu_req.
- cpu_addr  in  ADDR_W  address; latched with cpu_req.
- cpu_wdata  in  DATA_W  write data; latched with cpu_req.
- cpu_rdata  out  DATA_W  read data; updated only at read completion, held otherwise.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high whenever state is not IDLE.
- pin_addr  out  LANE_W  current address beat.
- pin_wdata  out  LANE_W  current write-data beat.
- pin_oe  out  LANE_W  bidirectional lane enable; all bits carry the same value.
- pin_rdata  in  LANE_W  read-data lane.
- pin_ready  in  1  external ready; a beat completes only on an edge where it is 1.
- pin_phase  out  2  0 = idle, 1 = send, 2 = turn, 3 = recv.
- pin_frame  out  1  high during send beat 0 only.
- pin_we  out  1  latched cpu_we; valid while busy.

## Operation
- Beat counts: AB = ADDR_W/LANE_W, DB = DATA_W/LANE_W, SB = max(AB, DB).
- Beat order is little-endian: beat k carries bits [k*LANE_W +: LANE_W].
- IDLE: when cpu_req = 1, latch addr, wdata and we, then go to SEND with beat 0.
- SEND: send beats 0..SB-1.
  - pin_addr carries address beat k, or 0 when k ≥ AB.
  - pin_wdata carries data beat k on writes when k < DB; otherwise it is 0.
  - pin_oe is all ones.
  - The beat advances on an edge where pin_ready = 1.
  - After beat SB-1, a write goes to DONE and a read goes to TURN.
- TURN: one cycle with pin_oe = 0; pin_ready is ignored. Then go to RECV.
- RECV: on each edge where pin_ready = 1, capture pin_rdata into data beat k. After beat DB-1, go to DONE.
- DONE: for one cycle, cpu_ack = 1 and cpu_rdata is updated (reads only). Then go to IDLE.
- cpu_req held high through DONE is sampled again in IDLE, which starts the next transaction.
- Reset values: all outputs are 0, state is IDLE, cpu_rdata is 0.
- Async reset mid-transaction aborts immediately. No ack is generated, pin_oe drops to 0 at once, and no partial data reaches cpu_rdata.
- pin_ready = 0 holds the current beat's outputs stable indefinitely. No timeout.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Acceptance edge E0. With pin_ready held at 1:
  - Write, 32/32/8: send beats in cycles 1–4, cpu_ack in cycle 5, back in IDLE in cycle 6.
  - Read, 32/32/8: send in cycles 1–4, turn in cycle 5, recv captures at the ends of cycles 6–9, cpu_ack and new cpu_rdata in cycle 10.
- Each cycle with pin_ready = 0 in SEND or RECV adds exactly one cycle of latency.
- Minimum request-to-request spacing is SB + 2 cycles for writes and SB + DB + 3 cycles for reads.

## Structure
- Shared package bridge_pkg contains:
  - the state enum {IDLE, SEND, TURN, RECV, DONE};
  - pin_phase encodings;
  - a beats(width, lane) constant function.
- Sub-module lane_shifter: a loadable parallel-in/serial-out and serial-in/parallel-out shift register with an enable, instantiated for the address, write-data and read-data paths.
- The beat counter is $clog2(SB + 1) bits wide and lives in the top FSM.
- Elaboration-time assertions check the width-divisibility rules.

## Test plan
- Write, 32/32/8, addr 0x12345678, wdata 0xCAFEBABE, pin_ready = 1:
  - pin_addr beats are 78, 56, 34, 12;
  - pin_wdata beats are BE, BA, FE, CA;
  - cpu_ack in cycle 5.
- Read, pin_rdata beats 0x11, 0x22, 0x33, 0x44: cpu_rdata = 0x44332211 on the ack cycle; pin_oe is 0 in TURN and RECV.
- Read with pin_ready low for 3 cycles at send beat 2 and 2 cycles at recv beat 1: outputs hold stable and ack arrives in cycle 15.
- Parameters ADDR_W = 16, DATA_W = 32, LANE_W = 8, write: SB = 4, and pin_addr is 0 on beats 2–3.
- rst_n asserted in RECV beat 2: outputs go to 0 immediately, there is no ack, cpu_rdata keeps its reset value 0, and the next request runs normally.
- cpu_req held high continuously: back-to-back writes are accepted with exactly one IDLE cycle between each ack and the next pin_frame.
